// File: rtl/pipelined_unmixer_pkg.sv
// Shared defaults for the unmixing pipeline.
// Recovers b = (q ^ c) - a from the mixing link.
package pipelined_unmixer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/pipelined_unmixer_if.sv
// Valid/ready bundle for the unmixer: triple in, recovered b out.
// Master drives the triple and out_ready; slave is the unmixer.
interface pipelined_unmixer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] in_c;
  logic [WIDTH-1:0] in_a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_b;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_q, in_c, in_a, out_ready,
    input  in_ready, out_valid, out_b, out_cnt
  );

  modport slave (
    input  in_valid, in_q, in_c, in_a, out_ready,
    output in_ready, out_valid, out_b, out_cnt
  );
endinterface

// File: rtl/pipelined_unmixer_stage.sv
// Data+valid pipeline register: loads upstream when load is high,
// otherwise holds. Data is reset too so nothing carries X.
module pipe_stage_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         valid,
  output logic [W-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= in_valid;
      data  <= in_data;
    end
  end
endmodule

// File: rtl/pipelined_unmixer.sv
// 3-stage unmixer: capture, xor with key, subtract addend.
// Ready chain lets a full pipe advance without bubbles.
module pipelined_unmixer
  import pipelined_unmixer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic             clk,
  input logic             rst,
  pipelined_unmixer_if.slave bus
);
  logic             v1, v2, v3;
  logic             rdy1, rdy2, rdy3;
  logic             v0;
  logic [3*WIDTH-1:0] d1;
  logic [2*WIDTH-1:0] d2;
  logic [WIDTH-1:0] q1, c1, a1;
  logic [WIDTH-1:0] s2, a2, b3;
  logic [CNT_W-1:0] cnt;

  assign rdy3 = !v3 || bus.out_ready;
  assign rdy2 = !v2 || rdy3;
  assign rdy1 = !v1 || rdy2;
  assign v0   = bus.in_valid && rdy1;

  assign {q1, c1, a1} = d1;
  assign {s2, a2}     = d2;

  pipe_stage_reg #(.W(3*WIDTH)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .load     (rdy1),
    .in_valid (v0),
    .in_data  ({bus.in_q, bus.in_c, bus.in_a}),
    .valid    (v1),
    .data     (d1)
  );

  pipe_stage_reg #(.W(2*WIDTH)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .load     (rdy2),
    .in_valid (v1),
    .in_data  ({q1 ^ c1, a1}),
    .valid    (v2),
    .data     (d2)
  );

  // Borrow falls off the top: result is mod 2^WIDTH.
  pipe_stage_reg #(.W(WIDTH)) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .load     (rdy3),
    .in_valid (v2),
    .in_data  (s2 - a2),
    .valid    (v3),
    .data     (b3)
  );

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (v3 && bus.out_ready)
      cnt <= cnt + 1'b1;
  end

  assign bus.in_ready  = rdy1;
  assign bus.out_valid = v3;
  assign bus.out_b     = b3;
  assign bus.out_cnt   = cnt;
endmodule
